// File: rtl/seq_alu.sv
// Registered ALU with handshakes on both sides: sixteen single-cycle functions plus
// a WIDTH-cycle shift-add unsigned multiply, with zero/carry/err flags stored alongside the result.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zero,
    output logic               carry,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [4:0]       OP_MUL   = 5'd16;
    localparam logic [WIDTH:0]   ONE_W1   = (WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 zero_q;
    logic                 carry_q;
    logic                 err_q;
    logic                 outValid_q;
    logic [2*WIDTH-1:0]   mulA_q;
    logic [WIDTH-1:0]     mulB_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH:0]       alu_d;
    logic [2*WIDTH-1:0]   res_d;
    logic                 illegal_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic                 accept;
    logic                 isMul;

    assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign isMul    = (op == OP_MUL);

    // Single-cycle functions produce WIDTH+1 bits; bit WIDTH is what the carry flag reports.
    always_comb begin
        alu_d     = '0;
        illegal_d = 1'b0;
        case (op)
            5'd0:  alu_d = {1'b0, a} + {1'b0, b};
            5'd1:  alu_d = {1'b0, a} - {1'b0, b};
            5'd2:  alu_d = {1'b0, a} + ONE_W1;
            5'd3:  alu_d = {1'b0, a} - ONE_W1;
            5'd4:  alu_d = {a, 1'b0};
            5'd5:  alu_d = {2'b00, a[WIDTH-1:1]};
            5'd6:  alu_d = {1'b0, a & b};
            5'd7:  alu_d = {{WIDTH{1'b0}}, (a == b)};
            5'd8:  alu_d = {1'b0, ~a};
            5'd9:  alu_d = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
            5'd10: alu_d = {1'b0, a[0], a[WIDTH-1:1]};
            5'd11: alu_d = {{WIDTH{1'b0}}, (a > b)};
            5'd12: alu_d = {{WIDTH{1'b0}}, (a < b)};
            5'd13: alu_d = {1'b0, a ^ b};
            5'd14: alu_d = {1'b0, ~(a ^ b)};
            5'd15: alu_d = {1'b0, a | b};
            5'd16: alu_d = '0;
            default: begin
                alu_d     = '0;
                illegal_d = 1'b1;
            end
        endcase
    end

    assign res_d = {{(WIDTH - 1){1'b0}}, alu_d};
    assign acc_d = acc_q + (mulB_q[0] ? mulA_q : '0);

    // One FSM owns every register; outputs stay frozen in DONE until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
            mulA_q     <= '0;
            mulB_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (isMul) begin
                            mulA_q     <= {{WIDTH{1'b0}}, a};
                            mulB_q     <= b;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            outValid_q <= 1'b0;
                            state_q    <= BUSY;
                        end else begin
                            result_q   <= res_d;
                            zero_q     <= (res_d == '0);
                            carry_q    <= alu_d[WIDTH];
                            err_q      <= illegal_d;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end else if (state_q == DONE && out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                BUSY: begin
                    mulA_q <= mulA_q << 1;
                    mulB_q <= mulB_q >> 1;
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_q + CNT_ONE;
                    // The last partial product is folded in on the same edge that publishes the result.
                    if (cnt_q == CNT_LAST) begin
                        result_q   <= acc_d;
                        zero_q     <= (acc_d == '0);
                        carry_q    <= acc_d[WIDTH];
                        err_q      <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign err       = err_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8: every expected value below is worked out by hand
// from the opcode definitions, including multiply latency, hold behaviour and mid-multiply reset.
module tb_seq_alu;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               inValid;
    logic               inReady;
    logic [4:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               outValid;
    logic               outReady;
    logic [2*WIDTH-1:0] result;
    logic               zero;
    logic               carry;
    logic               err;

    int checkCount = 0;
    int failCount  = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .in_ready (inReady),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(outValid),
        .out_ready(outReady),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a broken handshake can never stall the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] opIn, input logic [7:0] aIn, input logic [7:0] bIn,
                                 input logic validIn, input logic readyIn);
        op       = opIn;
        a        = aIn;
        b        = bIn;
        inValid  = validIn;
        outReady = readyIn;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic [15:0] expRes, input logic expCarry, input logic expErr);
        checkOutput({tag, ".valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expRes == 16'h0000));
        checkOutput({tag, ".carry"}, 32'(carry), 32'(expCarry));
        checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        carry;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{5'd2,  8'hFF, 8'h00, 16'h0100, 1'b1});
        vecs.push_back('{5'd3,  8'h00, 8'h00, 16'h01FF, 1'b1});
        vecs.push_back('{5'd4,  8'h80, 8'h00, 16'h0100, 1'b1});
        vecs.push_back('{5'd5,  8'h81, 8'h00, 16'h0040, 1'b0});
        vecs.push_back('{5'd6,  8'hF0, 8'h3C, 16'h0030, 1'b0});
        vecs.push_back('{5'd8,  8'h0F, 8'h00, 16'h00F0, 1'b0});
        vecs.push_back('{5'd10, 8'h01, 8'h00, 16'h0080, 1'b0});
        vecs.push_back('{5'd11, 8'h05, 8'h03, 16'h0001, 1'b0});
        vecs.push_back('{5'd12, 8'h05, 8'h03, 16'h0000, 1'b0});
        vecs.push_back('{5'd13, 8'hF0, 8'hFF, 16'h000F, 1'b0});
        vecs.push_back('{5'd14, 8'hF0, 8'h0F, 16'h0000, 1'b0});
        vecs.push_back('{5'd15, 8'hF0, 8'h0F, 16'h00FF, 1'b0});

        rst = 1'b1;
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        stepClock();
        stepClock();
        checkOutput("reset.valid", 32'(outValid), 32'd0);
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.flags", 32'({zero, carry, err}), 32'd0);
        checkOutput("reset.inReady", 32'(inReady), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle.inReady", 32'(inReady), 32'd1);

        // Add with carry out, then a back-to-back subtract and compare.
        applyStimulus(5'd0, 8'hFF, 8'h01, 1'b1, 1'b1);
        stepClock();
        checkResult("add", 16'h0100, 1'b1, 1'b0);
        checkOutput("add.inReady", 32'(inReady), 32'd1);
        applyStimulus(5'd1, 8'h03, 8'h05, 1'b1, 1'b1);
        stepClock();
        checkResult("sub", 16'h01FE, 1'b1, 1'b0);
        applyStimulus(5'd7, 8'h5A, 8'h5A, 1'b1, 1'b1);
        stepClock();
        checkResult("eq", 16'h0001, 1'b0, 1'b0);
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        stepClock();
        checkOutput("drain.valid", 32'(outValid), 32'd0);
        checkOutput("drain.inReady", 32'(inReady), 32'd1);

        // Multiply 0xFF*0xFF: eight busy cycles, result on the ninth edge.
        applyStimulus(5'd16, 8'hFF, 8'hFF, 1'b1, 1'b1);
        stepClock();
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("mul.busyReady%0d", i), 32'(inReady), 32'd0);
            checkOutput($sformatf("mul.busyValid%0d", i), 32'(outValid), 32'd0);
            if (i < 7) stepClock();
            else begin
                inValid = 1'b0;
                stepClock();
            end
        end
        checkResult("mulFF", 16'hFE01, 1'b0, 1'b0);
        stepClock();
        checkOutput("mulFF.drain", 32'(outValid), 32'd0);

        // Rotate left with the consumer stalled: result must hold and no new request is taken.
        applyStimulus(5'd9, 8'h81, 8'h00, 1'b1, 1'b0);
        stepClock();
        applyStimulus(5'd0, 8'h3C, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkResult($sformatf("rol.hold%0d", i), 16'h0003, 1'b0, 1'b0);
            checkOutput($sformatf("rol.inReady%0d", i), 32'(inReady), 32'd0);
            stepClock();
        end
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        #1;
        checkOutput("rol.readyOnConsume", 32'(inReady), 32'd1);
        stepClock();
        checkOutput("rol.drain", 32'(outValid), 32'd0);
        checkOutput("rol.idleReady", 32'(inReady), 32'd1);

        // Illegal opcode, then a zero sum that clears err.
        applyStimulus(5'd20, 8'h00, 8'h00, 1'b1, 1'b1);
        stepClock();
        checkResult("illegal", 16'h0000, 1'b0, 1'b1);
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        stepClock();
        checkResult("zeroAdd", 16'h0000, 1'b0, 1'b0);

        // Remaining single-cycle opcodes streamed back-to-back.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b1);
            stepClock();
            checkResult($sformatf("op%0d", vecs[i].op), vecs[i].res, vecs[i].carry, 1'b0);
        end
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        stepClock();

        // Reset during the fourth busy cycle aborts the multiply.
        applyStimulus(5'd16, 8'h07, 8'h09, 1'b1, 1'b1);
        stepClock();
        applyStimulus(5'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        stepClock();
        stepClock();
        stepClock();
        rst = 1'b1;
        #1;
        checkOutput("abort.valid", 32'(outValid), 32'd0);
        checkOutput("abort.result", 32'(result), 32'd0);
        checkOutput("abort.flags", 32'({zero, carry, err}), 32'd0);
        checkOutput("abort.inReady", 32'(inReady), 32'd0);
        stepClock();
        rst = 1'b0;
        #1;
        checkOutput("abort.idleReady", 32'(inReady), 32'd1);
        stepClock();
        checkOutput("abort.noOutput", 32'(outValid), 32'd0);

        // Fresh multiply; operands change right after accept and must not matter.
        applyStimulus(5'd16, 8'h07, 8'h09, 1'b1, 1'b1);
        stepClock();
        applyStimulus(5'd0, 8'hAA, 8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) stepClock();
        checkResult("mul7x9", 16'h003F, 1'b0, 1'b0);
        stepClock();
        checkOutput("mul7x9.drain", 32'(outValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
